ipf_tile_sched: RTL and testbench

- Tile scheduler that feeds and sequences the IPF 8-cube 3x3 convolution engine.
- Per tile: fetches weight words and input rows from a 64-bit on-chip SRAM port and pushes them into IPF through i_valid/w_valid while IPF is in WAIT.
- Then drives ctrl START for a fixed compute window, HOLD to return IPF to WAIT, and END after the last tile.
- Sits between the configuration register block and the IPF instance.

---
 rtl/ipf_pkg.sv | 28 ++
 rtl/ipf_mem_rd.sv | 77 +++++++
 rtl/ipf_tile_sched.sv | 204 ++++++++++++++++++++
 tb/tb_ipf_tile_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipf_pkg.sv
// Shared IPF control codes, tile scheduler states and default tile geometry.
// The scheduler's optional read watchdog is enabled by IPF_TILE_SCHED_TIMEOUT_EN.
package ipf_pkg;

    localparam logic [1:0] IPF_END   = 2'd0;
    localparam logic [1:0] IPF_START = 2'd1;
    localparam logic [1:0] IPF_HOLD  = 2'd2;

    localparam int IPF_ROWS_PER_TILE = 8;
    localparam int IPF_W_WORDS       = 4;
    localparam int IPF_COMPUTE_CYC   = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_I,
        ST_ISSUE,
        ST_RUN,
        ST_HOLD,
        ST_FIN
    } sched_state_t;

    // Bits needed to hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ipf_mem_rd.sv
// Single-outstanding SRAM read requester: issues 'count' reads at consecutive
// addresses from 'base'. Optional watchdog under IPF_TILE_SCHED_TIMEOUT_EN.
module ipf_mem_rd #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    output logic              beat,
    output logic              last
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    logic             outstanding;
    logic [CNT_W-1:0] remaining;

    // A response in the request cycle itself cannot belong to this read.
    assign beat = outstanding && !mem_req && mem_rvalid;
    assign last = beat && (remaining == CNT_W'(1));

`ifdef IPF_TILE_SCHED_TIMEOUT_EN
    logic [7:0] wd;
    assign timeout = outstanding && !beat && (wd == 8'd254);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            outstanding <= 1'b0;
            remaining   <= '0;
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
            wd          <= '0;
`endif
        end else begin
            mem_req <= 1'b0;
            if (start && count != '0) begin
                mem_req     <= 1'b1;
                mem_addr    <= base;
                remaining   <= count;
                outstanding <= 1'b1;
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
                wd          <= '0;
`endif
            end else if (beat) begin
                remaining <= remaining - 1'b1;
                if (last) begin
                    outstanding <= 1'b0;
                end else begin
                    mem_req  <= 1'b1;
                    mem_addr <= mem_addr + 1'b1;
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
                    wd       <= '0;
`endif
                end
            end
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
            else if (timeout) begin
                outstanding <= 1'b0;
                remaining   <= '0;
            end else if (outstanding) begin
                wd <= wd + 8'd1;
            end
`endif
        end
    end

endmodule

// File: rtl/ipf_tile_sched.sv
// Tile scheduler for the IPF 3x3 convolution engine: loads weights and rows,
// runs a fixed START window per tile, ENDs after the last tile. Macro: IPF_TILE_SCHED_TIMEOUT_EN.
module ipf_tile_sched
    import ipf_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int ROWS_PER_TILE = IPF_ROWS_PER_TILE,
    parameter int W_WORDS       = IPF_W_WORDS,
    parameter int COMPUTE_CYC   = IPF_COMPUTE_CYC,
    parameter int TILE_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic [ADDR_W-1:0] cfg_i_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    output logic [1:0]        ipf_ctrl,
    output logic [63:0]       ipf_i_data,
    output logic              ipf_i_valid,
    output logic [63:0]       ipf_w_data,
    output logic              ipf_w_valid,
    input  logic              ipf_res_valid,
    output logic [15:0]       res_cnt
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    localparam int RD_CNT_W = cnt_w((W_WORDS > ROWS_PER_TILE) ? W_WORDS : ROWS_PER_TILE);
    localparam int RUN_W    = cnt_w(COMPUTE_CYC);

    sched_state_t        state;
    logic [TILE_W-1:0]   tiles_left;
    logic [ADDR_W-1:0]   w_ptr;
    logic [ADDR_W-1:0]   i_ptr;
    logic [RUN_W-1:0]    run_cnt;
    logic                rd_start;
    logic [ADDR_W-1:0]   rd_base;
    logic [RD_CNT_W-1:0] rd_cnt;
    logic                rd_beat;
    logic                rd_last;
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
    logic                rd_timeout;
`endif

    ipf_mem_rd #(
        .ADDR_W (ADDR_W),
        .CNT_W  (RD_CNT_W)
    ) u_rd (
        .clk        (clk),
        .rst        (rst),
        .start      (rd_start),
        .base       (rd_base),
        .count      (rd_cnt),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .beat       (rd_beat),
        .last       (rd_last)
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
        ,
        .timeout    (rd_timeout)
`endif
    );

    // ipf_ctrl is registered, so it lags the state by one cycle: the START
    // window spans ISSUE's successor through the HOLD state (COMPUTE_CYC+1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ipf_ctrl    <= IPF_HOLD;
            ipf_i_data  <= '0;
            ipf_i_valid <= 1'b0;
            ipf_w_data  <= '0;
            ipf_w_valid <= 1'b0;
            res_cnt     <= '0;
            tiles_left  <= '0;
            w_ptr       <= '0;
            i_ptr       <= '0;
            run_cnt     <= '0;
            rd_start    <= 1'b0;
            rd_base     <= '0;
            rd_cnt      <= '0;
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
            err         <= 1'b0;
`endif
        end else begin
            rd_start    <= 1'b0;
            ipf_i_valid <= 1'b0;
            ipf_w_valid <= 1'b0;
            done        <= 1'b0;
            if (busy && ipf_res_valid && res_cnt != 16'hFFFF)
                res_cnt <= res_cnt + 16'd1;

            case (state)
                ST_IDLE: begin
                    ipf_ctrl <= IPF_HOLD;
                    busy     <= 1'b0;
                    // busy is still high in the END cycle, so a start there is dropped
                    if (cfg_start && !busy) begin
                        busy       <= 1'b1;
                        res_cnt    <= '0;
                        tiles_left <= cfg_tiles;
                        w_ptr      <= cfg_w_base;
                        i_ptr      <= cfg_i_base;
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
                        err        <= 1'b0;
`endif
                        if (cfg_tiles == '0) begin
                            state <= ST_FIN;
                        end else begin
                            state    <= ST_LOAD_W;
                            rd_start <= 1'b1;
                            rd_base  <= cfg_w_base;
                            rd_cnt   <= RD_CNT_W'(W_WORDS);
                        end
                    end
                end

                ST_LOAD_W: begin
                    if (rd_beat) begin
                        ipf_w_valid <= 1'b1;
                        ipf_w_data  <= mem_rdata;
                    end
                    if (rd_last) begin
                        w_ptr    <= w_ptr + ADDR_W'(W_WORDS);
                        state    <= ST_LOAD_I;
                        rd_start <= 1'b1;
                        rd_base  <= i_ptr;
                        rd_cnt   <= RD_CNT_W'(ROWS_PER_TILE);
                    end
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
                    if (rd_timeout) begin
                        err   <= 1'b1;
                        state <= ST_FIN;
                    end
`endif
                end

                ST_LOAD_I: begin
                    if (rd_beat) begin
                        ipf_i_valid <= 1'b1;
                        ipf_i_data  <= mem_rdata;
                    end
                    if (rd_last) begin
                        i_ptr <= i_ptr + ADDR_W'(ROWS_PER_TILE);
                        state <= ST_ISSUE;
                    end
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
                    if (rd_timeout) begin
                        err   <= 1'b1;
                        state <= ST_FIN;
                    end
`endif
                end

                ST_ISSUE: begin
                    ipf_ctrl <= IPF_START;
                    run_cnt  <= RUN_W'(COMPUTE_CYC - 1);
                    state    <= ST_RUN;
                end

                ST_RUN: begin
                    if (run_cnt == '0)
                        state <= ST_HOLD;
                    else
                        run_cnt <= run_cnt - 1'b1;
                end

                ST_HOLD: begin
                    ipf_ctrl   <= IPF_HOLD;
                    tiles_left <= tiles_left - 1'b1;
                    if (tiles_left == TILE_W'(1)) begin
                        state <= ST_FIN;
                    end else begin
                        state    <= ST_LOAD_W;
                        rd_start <= 1'b1;
                        rd_base  <= w_ptr;
                        rd_cnt   <= RD_CNT_W'(W_WORDS);
                    end
                end

                ST_FIN: begin
                    ipf_ctrl <= IPF_END;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipf_tile_sched.sv
// Randomized scoreboard bench for ipf_tile_sched: a job model fills expectation
// queues, a negedge monitor compares every DUT strobe, request and done pulse.
module tb_ipf_tile_sched;
    import ipf_pkg::*;

    localparam int NW  = 4;
    localparam int NR  = 8;
    localparam int WIN = 32;   // COMPUTE_CYC + 1 START cycles per tile

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [7:0]  cfg_tiles;
    logic [15:0] cfg_i_base, cfg_w_base;
    logic        busy, done, mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic [1:0]  ipf_ctrl;
    logic [63:0] ipf_i_data, ipf_w_data;
    logic        ipf_i_valid, ipf_w_valid, ipf_res_valid;
    logic [15:0] res_cnt;
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
    logic        err;
`endif

    ipf_tile_sched dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_tiles     (cfg_tiles),
        .cfg_i_base    (cfg_i_base),
        .cfg_w_base    (cfg_w_base),
        .busy          (busy),
        .done          (done),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .ipf_ctrl      (ipf_ctrl),
        .ipf_i_data    (ipf_i_data),
        .ipf_i_valid   (ipf_i_valid),
        .ipf_w_data    (ipf_w_data),
        .ipf_w_valid   (ipf_w_valid),
        .ipf_res_valid (ipf_res_valid),
        .res_cnt       (res_cnt)
`ifdef IPF_TILE_SCHED_TIMEOUT_EN
        ,
        .err           (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [15:0] exp_addr[$];
    logic [63:0] exp_w[$];
    logic [63:0] exp_i[$];
    logic [15:0] exp_res[$];

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    bit          noise = 0;
    bit          stall_en = 0;
    bit          late_go = 0;
    logic [15:0] stall_addr = '0;

    function automatic logic [63:0] mdata(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5A5A, a + 16'h1234};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SRAM model: one response per request, random latency, optional stall.
    initial begin
        logic [15:0] a;
        int          lat;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(posedge clk); #1;
        forever begin
            if (mem_req && !rst) begin
                a = mem_addr;
                if (stall_en && a == stall_addr) begin
                    while (!late_go) begin @(posedge clk); #1; end
                    @(posedge clk); #1;
                end else begin
                    lat = int'($urandom_range(lat_max, lat_min));
                    repeat (lat) @(posedge clk);
                    #1;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = mdata(a);
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // IPF stand-in: results valid during START, plus idle noise on request.
    initial begin
        ipf_res_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            ipf_res_valid = (ipf_ctrl == IPF_START) || (noise && $urandom_range(1, 0) == 1);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic post(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.nm = nm; c.act = act; c.exp = exp;
        chk_q.push_back(c);
    endtask

    // Monitor: all comparisons happen here.
    initial begin
        chk_t       c;
        logic [1:0] prev_ctrl = IPF_HOLD;
        int         run_len = 0, w_seen = 0, i_seen = 0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                chk(c.nm, c.act, c.exp);
            end
            if (rst) begin
                prev_ctrl = IPF_HOLD; run_len = 0; w_seen = 0; i_seen = 0;
            end else begin
                if (mem_req) begin
                    if (exp_addr.size() == 0) chk("mem_req_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
                    else chk("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
                end
                if (ipf_w_valid) begin
                    chk("w_before_i", 64'(i_seen), 64'd0);
                    if (exp_w.size() == 0) chk("w_valid_unexpected", ipf_w_data, 64'hDEAD);
                    else chk("w_data", ipf_w_data, exp_w.pop_front());
                    w_seen++;
                end
                if (ipf_i_valid) begin
                    chk("i_after_w", 64'(w_seen), 64'(NW));
                    chk("w_i_same_cycle", 64'(ipf_w_valid), 64'd0);
                    if (exp_i.size() == 0) chk("i_valid_unexpected", ipf_i_data, 64'hDEAD);
                    else chk("i_data", ipf_i_data, exp_i.pop_front());
                    i_seen++;
                end
                if (ipf_ctrl == IPF_START && prev_ctrl != IPF_START) begin
                    chk("loads_before_start", 64'(w_seen * 100 + i_seen), 64'(NW * 100 + NR));
                    w_seen = 0; i_seen = 0;
                end
                if (ipf_ctrl == IPF_START) begin
                    run_len++;
                end else if (prev_ctrl == IPF_START) begin
                    chk("start_window_len", 64'(run_len), 64'(WIN));
                    chk("hold_after_start", 64'(ipf_ctrl), 64'(IPF_HOLD));
                    run_len = 0;
                end
                if (ipf_ctrl == 2'd3) chk("ctrl_code", 64'(ipf_ctrl), 64'(IPF_HOLD));
                if (done || ipf_ctrl == IPF_END) begin
                    chk("done_with_end", {62'd0, done, ipf_ctrl == IPF_END}, 64'd3);
                    chk("hold_before_end", 64'(prev_ctrl), 64'(IPF_HOLD));
                    chk("reads_left_at_end", 64'(exp_addr.size()), 64'd0);
                    if (exp_res.size() == 0) chk("done_unexpected", 64'(res_cnt), 64'hFFFF_FFFF);
                    else chk("res_cnt_at_done", 64'(res_cnt), 64'(exp_res.pop_front()));
                end
                prev_ctrl = ipf_ctrl;
            end
        end
    end

    // Reference model: contiguous weight/row addresses per tile, WIN results per tile.
    task automatic model(input int tiles, input logic [15:0] wb, input logic [15:0] ib);
        logic [15:0] wp = wb, ip = ib;
        for (int t = 0; t < tiles; t++) begin
            for (int k = 0; k < NW; k++) begin
                exp_addr.push_back(wp); exp_w.push_back(mdata(wp)); wp = wp + 16'd1;
            end
            for (int k = 0; k < NR; k++) begin
                exp_addr.push_back(ip); exp_i.push_back(mdata(ip)); ip = ip + 16'd1;
            end
        end
        exp_res.push_back(16'(tiles * WIN));
    endtask

    task automatic run_job(input int tiles, input logic [15:0] wb, input logic [15:0] ib,
                           input int lmin, input int lmax, input bit mid, output int dur);
        int c, sc;
        bit got, pulsed;
        model(tiles, wb, ib);
        lat_min = lmin; lat_max = lmax;
        cfg_tiles = 8'(tiles); cfg_w_base = wb; cfg_i_base = ib; cfg_start = 1'b1;
        c = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        got = 0; pulsed = 0; sc = 0; dur = -1;
        for (int k = 0; k < 20000 && !got; k++) begin
            if (done) begin
                got = 1; dur = cyc - c;
            end else begin
                if (mid && !pulsed && ipf_ctrl == IPF_START) begin
                    sc++;
                    if (sc == 10) begin
                        cfg_tiles = 8'd5; cfg_w_base = 16'h7000; cfg_i_base = 16'h7100;
                        cfg_start = 1'b1; pulsed = 1;
                    end
                end
                @(posedge clk); #1;
                cfg_start = 1'b0;
            end
        end
        post("job_completed", 64'(got), 64'd1);
        post("busy_at_done", 64'(busy), 64'd1);
        @(posedge clk); #1;
        post("busy_after_done", 64'(busy), 64'd0);
        post("ctrl_hold_when_idle", 64'(ipf_ctrl), 64'(IPF_HOLD));
        noise = 1;
        repeat (6) @(posedge clk);
        #1 noise = 0;
        @(posedge clk); #1;
        post("res_cnt_idle_frozen", 64'(res_cnt), 64'(tiles * WIN));
    endtask

    initial begin
        int  d, d1, d2;
        bit  got;
        rst = 1'b0; cfg_start = 1'b0; cfg_tiles = '0; cfg_i_base = '0; cfg_w_base = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        post("rst_busy_done_req", {61'd0, busy, done, mem_req}, 64'd0);
        post("rst_ctrl", 64'(ipf_ctrl), 64'(IPF_HOLD));
        post("rst_res_cnt", 64'(res_cnt), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_job(1, 16'h0010, 16'h0100, 1, 1, 0, d);
        run_job(3, 16'h0010, 16'h0100, 3, 3, 0, d);
        run_job(0, 16'h0040, 16'h0400, 1, 1, 0, d);
        post("tiles0_end_latency", 64'(d), 64'd2);
        run_job(2, 16'h0200, 16'h0300, 1, 1, 0, d1);
        run_job(2, 16'h0200, 16'h0300, 1, 1, 1, d2);
        post("midrun_start_ignored_timing", 64'(d2), 64'(d1));
        run_job(2, 16'hFFFE, 16'hFFFA, 1, 4, 0, d);
        for (int j = 0; j < 6; j++)
            run_job(int'($urandom_range(3, 1)), 16'($urandom), 16'($urandom), 1, 4, 0, d);

        // Reset while an input-row read is outstanding.
        model(1, 16'h0500, 16'h0600);
        lat_min = 2; lat_max = 2;
        stall_addr = 16'h0603; stall_en = 1;
        cfg_tiles = 8'd1; cfg_w_base = 16'h0500; cfg_i_base = 16'h0600; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        got = 0;
        for (int k = 0; k < 2000 && !got; k++) begin
            if (mem_req && mem_addr == 16'h0603) got = 1;
            else begin @(posedge clk); #1; end
        end
        post("stall_read_reached", 64'(got), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        post("midrst_busy_done_req_vld", {59'd0, busy, done, mem_req, ipf_i_valid, ipf_w_valid}, 64'd0);
        post("midrst_mem_addr", 64'(mem_addr), 64'd0);
        post("midrst_ctrl", 64'(ipf_ctrl), 64'(IPF_HOLD));
        post("midrst_i_data", ipf_i_data, 64'd0);
        post("midrst_w_data", ipf_w_data, 64'd0);
        post("midrst_res_cnt", 64'(res_cnt), 64'd0);
        exp_addr.delete(); exp_w.delete(); exp_i.delete(); exp_res.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        late_go = 1;
        repeat (6) @(posedge clk);
        #1;
        post("late_rvalid_busy", 64'(busy), 64'd0);
        post("late_rvalid_ctrl", 64'(ipf_ctrl), 64'(IPF_HOLD));
        stall_en = 0; late_go = 0;

        run_job(1, 16'h0800, 16'h0900, 1, 3, 0, d);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
